// File: rtl/blackjack_pkg.sv
// Shared blackjack definitions: rank codes, deck geometry, dealer FSM states
// and the slot-to-rank mapping used by the card dealer.
package blackjack_pkg;

    localparam int DECK_SIZE = 52;
    localparam int SLOT_W    = 6;

    typedef enum logic [3:0] {
        AS     = 4'd1,
        DOIS   = 4'd2,
        TRES   = 4'd3,
        QUATRO = 4'd4,
        CINCO  = 4'd5,
        SEIS   = 4'd6,
        SETE   = 4'd7,
        OITO   = 4'd8,
        NOVE   = 4'd9,
        DEZ    = 4'd10,
        VALETE = 4'd11,
        DAMA   = 4'd12,
        REI    = 4'd13
    } rank_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PROBE   = 2'd1,
        ST_DELIVER = 2'd2
    } dealer_state_e;

    // Slot i carries rank (i mod 13)+1; a compare ladder avoids a divider.
    function automatic rank_e rank_of_index(input logic [SLOT_W-1:0] idx);
        logic [SLOT_W-1:0] r;
        if (idx >= 6'd39)      r = idx - 6'd39;
        else if (idx >= 6'd26) r = idx - 6'd26;
        else if (idx >= 6'd13) r = idx - 6'd13;
        else                   r = idx;
        return rank_e'(r[3:0] + 4'd1);
    endfunction

    function automatic logic [SLOT_W-1:0] slot_of_seed(input logic [SLOT_W-1:0] seed);
        return (seed >= 6'd52) ? seed - 6'd52 : seed;
    endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running 6-bit Fibonacci LFSR (x^6+x^5+1) used as an internal start-slot
// source; seeded to 6'b000001 on reset and stepped every cycle.
module card_lfsr (
    input  logic       clk,
    input  logic       reset,
    output logic [5:0] lfsr_o
);

    logic [5:0] lfsr_q;
    logic [5:0] lfsr_d;

    assign lfsr_d = {lfsr_q[4:0], lfsr_q[5] ^ lfsr_q[4]};
    assign lfsr_o = lfsr_q;

    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= 6'b000001;
        else       lfsr_q <= lfsr_d;
    end

endmodule

// File: rtl/card_dealer.sv
// Single-deck card source with draw-without-replacement by linear probing.
// Build option CARD_DEALER_LFSR_EN takes the start slot from an internal LFSR.
//
//   state   | meaning
//   IDLE    | ready, waits for draw_req
//   PROBE   | walks ptr forward until a present slot is found
//   DELIVER | card_valid strobe, then back to IDLE
module card_dealer
    import blackjack_pkg::*;
#(
    parameter int RAND_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restock,
    input  logic              draw_req,
    input  logic [RAND_W-1:0] random,
    output logic              ready,
    output logic              card_valid,
    output logic [3:0]        card_rank,
    output logic [5:0]        card_index,
    output logic [5:0]        cards_left,
    output logic              empty,
    output logic              err
);

    dealer_state_e    state_q, state_d;
    logic [DECK_SIZE-1:0] present_q, present_d;
    logic [5:0]       ptr_q, ptr_d;
    logic [5:0]       left_q, left_d;
    logic [3:0]       rank_q, rank_d;
    logic [5:0]       index_q, index_d;
    logic             err_q, err_d;
    logic [5:0]       seed_w;

`ifdef CARD_DEALER_LFSR_EN
    card_lfsr u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .lfsr_o (seed_w)
    );
`else
    assign seed_w = random[5:0];
`endif

    always_comb begin
        state_d   = state_q;
        present_d = present_q;
        ptr_d     = ptr_q;
        left_d    = left_q;
        rank_d    = rank_q;
        index_d   = index_q;
        err_d     = 1'b0;
        if (restock) begin
            // Restock overrides everything, including a same-cycle request.
            state_d   = ST_IDLE;
            present_d = '1;
            left_d    = 6'(DECK_SIZE);
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (draw_req) begin
                        if (left_q != 6'd0) begin
                            ptr_d   = slot_of_seed(seed_w);
                            state_d = ST_PROBE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_PROBE: begin
                    if (present_q[ptr_q]) begin
                        present_d[ptr_q] = 1'b0;
                        left_d           = left_q - 6'd1;
                        rank_d           = rank_of_index(ptr_q);
                        index_d          = ptr_q;
                        state_d          = ST_DELIVER;
                    end else begin
                        ptr_d = (ptr_q == 6'(DECK_SIZE - 1)) ? 6'd0 : ptr_q + 6'd1;
                    end
                end
                ST_DELIVER: state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            present_q <= '1;
            ptr_q     <= 6'd0;
            left_q    <= 6'(DECK_SIZE);
            rank_q    <= 4'd0;
            index_q   <= 6'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            present_q <= present_d;
            ptr_q     <= ptr_d;
            left_q    <= left_d;
            rank_q    <= rank_d;
            index_q   <= index_d;
            err_q     <= err_d;
        end
    end

    assign ready      = (state_q == ST_IDLE);
    assign card_valid = (state_q == ST_DELIVER);
    assign card_rank  = rank_q;
    assign card_index = index_q;
    assign cards_left = left_q;
    assign empty      = (left_q == 6'd0);
    assign err        = err_q;

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer (default build, start slot from random):
// a reference deck model pushes expected cards, popped when card_valid fires.
module tb_card_dealer;

    typedef struct {
        int idx;
        int rank;
        int left;
        int lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       restock;
    logic       draw_req;
    logic [5:0] random;
    logic       ready, card_valid, empty, err;
    logic [3:0] card_rank;
    logic [5:0] card_index, cards_left;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    bit   m_present[52];
    int   m_left;
    bit   seen[52];
    int   last_rank;

    card_dealer #(.RAND_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .restock    (restock),
        .draw_req   (draw_req),
        .random     (random),
        .ready      (ready),
        .card_valid (card_valid),
        .card_rank  (card_rank),
        .card_index (card_index),
        .cards_left (cards_left),
        .empty      (empty),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_fill();
        for (int i = 0; i < 52; i++) m_present[i] = 1'b1;
        m_left = 52;
    endtask

    // Called at a negedge; returns at a negedge with the DUT back in IDLE.
    task automatic draw(input logic [5:0] r);
        exp_t e;
        int   slot;
        int   k;
        bit   got;
        bit   want_err;
        int   n;
        n = 0;
        while (!ready && n < 100) begin @(negedge clk); n++; end
        if (!ready) check_eq("ready_timeout", 0, 1);
        draw_req = 1'b1;
        random   = r;
        want_err = (m_left == 0);
        if (!want_err) begin
            slot = (r >= 52) ? r - 52 : r;
            k    = 0;
            while (!m_present[slot]) begin
                slot = (slot == 51) ? 0 : slot + 1;
                k++;
            end
            m_present[slot] = 1'b0;
            m_left--;
            e.idx  = slot;
            e.rank = slot % 13 + 1;
            e.left = m_left;
            e.lat  = 2 + k;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 draw_req = 1'b0;
        if (want_err) begin
            @(negedge clk);
            check_eq("err_pulse", err, 1);
            check_eq("err_no_valid", card_valid, 0);
            check_eq("err_ready", ready, 1);
            @(negedge clk);
            check_eq("err_one_cycle", err, 0);
            check_eq("err_no_valid2", card_valid, 0);
            check_eq("err_left", cards_left, 0);
            check_eq("err_rank_hold", card_rank, last_rank);
        end else begin
            got = 1'b0;
            for (int c = 1; c <= 60 && !got; c++) begin
                @(negedge clk);
                if (c == 1) check_eq("ready_low", ready, 0);
                if (err) check_eq("spurious_err", err, 0);
                if (card_valid) begin
                    got = 1'b1;
                    e   = sb.pop_front();
                    check_eq("latency", c, e.lat);
                    check_eq("card_index", card_index, e.idx);
                    check_eq("card_rank", card_rank, e.rank);
                    check_eq("cards_left", cards_left, e.left);
                    check_eq("empty", empty, (e.left == 0) ? 1 : 0);
                    check_eq("distinct", seen[e.idx], 0);
                    seen[e.idx] = 1'b1;
                    last_rank   = e.rank;
                end
            end
            if (!got) begin
                check_eq("valid_timeout", 0, 1);
                void'(sb.pop_front());
            end
            @(negedge clk);
            check_eq("valid_one_cycle", card_valid, 0);
            check_eq("ready_back", ready, 1);
        end
    endtask

    task automatic do_restock();
        restock = 1'b1;
        @(posedge clk);
        #1 restock = 1'b0;
        model_fill();
        for (int i = 0; i < 52; i++) seen[i] = 1'b0;
        @(negedge clk);
        check_eq("restock_left", cards_left, 52);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        restock  = 1'b0;
        draw_req = 1'b0;
        random   = '0;
        last_rank = 0;
        model_fill();
        for (int i = 0; i < 52; i++) seen[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", ready, 1);
        check_eq("rst_left", cards_left, 52);
        check_eq("rst_empty", empty, 0);
        check_eq("rst_valid", card_valid, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_rank", card_rank, 0);
        check_eq("rst_index", card_index, 0);

        draw(6'd0);
        draw(6'd0);

        do_restock();
        draw(6'd63);
        draw(6'd51);
        draw(6'd51);

        // Restock while the draw is in PROBE: the pending card is dropped.
        draw_req = 1'b1;
        random   = 6'd20;
        @(posedge clk);
        #1 draw_req = 1'b0;
        restock = 1'b1;
        @(posedge clk);
        #1 restock = 1'b0;
        model_fill();
        for (int i = 0; i < 52; i++) seen[i] = 1'b0;
        @(negedge clk);
        check_eq("probe_rst_ready", ready, 1);
        check_eq("probe_rst_left", cards_left, 52);
        check_eq("probe_rst_valid", card_valid, 0);
        repeat (3) begin
            @(negedge clk);
            check_eq("probe_rst_novalid", card_valid, 0);
        end

        draw(6'd5);
        draw(6'd5);

        // Full deck drain with random seeds, then request on an empty deck.
        do_restock();
        for (int i = 0; i < 52; i++) draw(6'($urandom_range(0, 63)));
        check_eq("drained_empty", empty, 1);
        check_eq("drained_left", cards_left, 0);
        draw(6'd7);

        // Restock and draw_req together on an empty deck: restock wins, no err.
        restock  = 1'b1;
        draw_req = 1'b1;
        random   = 6'd3;
        @(posedge clk);
        #1 begin restock = 1'b0; draw_req = 1'b0; end
        model_fill();
        for (int i = 0; i < 52; i++) seen[i] = 1'b0;
        @(negedge clk);
        check_eq("same_ready", ready, 1);
        check_eq("same_left", cards_left, 52);
        check_eq("same_valid", card_valid, 0);
        check_eq("same_err", err, 0);
        check_eq("same_empty", empty, 0);
        repeat (3) begin
            @(negedge clk);
            check_eq("same_novalid", card_valid, 0);
            check_eq("same_noerr", err, 0);
        end

        draw(6'd12);
        check_eq("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
